// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder: one full-adder cell plus a carry flop, WIDTH cycles per sum.
// Optional signed-overflow output V_out is enabled by defining BIT_SERIAL_ADDER_OVF_EN.
module bit_serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic             C_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] S_out,
    output logic             C_out
`ifdef BIT_SERIAL_ADDER_OVF_EN
    ,
    output logic             V_out
`endif
);

    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
    localparam int unsigned PSUM_W = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [WIDTH-1:0]   a_q, a_nxt;
    logic [WIDTH-1:0]   b_q, b_nxt;
    logic               carry_q, carry_nxt;
    // The final sum bit goes straight to S_out, so only WIDTH-1 partial bits are stored.
    logic [PSUM_W-1:0]  psum_q, psum_nxt;
    logic [WIDTH-1:0]   s_nxt;
    logic               co_nxt;
    logic               busy_nxt;
    logic               done_nxt;
`ifdef BIT_SERIAL_ADDER_OVF_EN
    logic               v_nxt;
`endif

    logic fa_sum;
    logic fa_carry;

    // Single full-adder cell
    assign fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
    assign fa_carry = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        a_nxt     = a_q;
        b_nxt     = b_q;
        carry_nxt = carry_q;
        psum_nxt  = psum_q;
        s_nxt     = S_out;
        co_nxt    = C_out;
        done_nxt  = 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
        v_nxt     = V_out;
`endif

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    a_nxt     = A_in;
                    b_nxt     = B_in;
                    carry_nxt = C_in;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                a_nxt     = {1'b0, a_q[WIDTH-1:1]};
                b_nxt     = {1'b0, b_q[WIDTH-1:1]};
                carry_nxt = fa_carry;
                psum_nxt  = PSUM_W'({fa_sum, psum_q} >> 1);
                cnt_nxt   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // Last bit: publish the result as the FSM enters DONE
                    s_nxt     = {fa_sum, psum_q};
                    co_nxt    = fa_carry;
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
`ifdef BIT_SERIAL_ADDER_OVF_EN
                    v_nxt     = carry_q ^ fa_carry;
`endif
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            psum_q   <= '0;
            S_out    <= '0;
            C_out    <= 1'b0;
            busy_out <= 1'b0;
            done_out <= 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
            V_out    <= 1'b0;
`endif
        end else begin
            cnt_q    <= cnt_nxt;
            a_q      <= a_nxt;
            b_q      <= b_nxt;
            carry_q  <= carry_nxt;
            psum_q   <= psum_nxt;
            S_out    <= s_nxt;
            C_out    <= co_nxt;
            busy_out <= busy_nxt;
            done_out <= done_nxt;
`ifdef BIT_SERIAL_ADDER_OVF_EN
            V_out    <= v_nxt;
`endif
        end
    end

endmodule

// File: doc/bit_serial_adder.md
BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk_in  input  1  Single clock; all state changes on its rising edge.
REQ-003 rst_in  input  1  Reset; asynchronous, active-high.
REQ-004 start_in  input  1  Request to start an addition; sampled on rising edge.
REQ-005 A_in  input  WIDTH  Operand A; unsigned or two's complement.
REQ-006 B_in  input  WIDTH  Operand B.
REQ-007 C_in  input  1  Carry-in for the LSB.
REQ-008 busy_out  output  1  High while an addition is in progress.
REQ-009 done_out  output  1  One-cycle pulse; result valid.
REQ-010 S_out  output  WIDTH  Registered sum.
REQ-011 C_out  output  1  Registered carry-out of the MSB.

Function
REQ-012 The block SHALL add LSB-first, one bit per clock, using one full-adder cell (sum = a^b^c, carry = a&b | c&(a^b)) and a carry flip-flop.
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE, plus a bit counter of ceil(log2(WIDTH+1)) bits.
REQ-014 IDLE: start_in=1 at edge k SHALL latch A_in, B_in into shift registers and C_in into the carry flop, clear the counter and enter SHIFT; start_in=0 keeps IDLE.
REQ-015 SHIFT: each cycle SHALL feed the operand LSBs and carry flop to the adder, shift the sum bit into the MSB of a partial-sum register, shift the operands right by one, update the carry flop and increment the counter.
REQ-016 After exactly WIDTH SHIFT cycles (cycles k+1..k+WIDTH), the FSM SHALL enter DONE at cycle k+WIDTH+1.
REQ-017 On entry to DONE, S_out and C_out SHALL load the partial sum and the final carry; done_out SHALL be high only during the DONE cycle; the next state SHALL be IDLE.
REQ-018 busy_out SHALL be high in SHIFT and DONE and low in IDLE.
REQ-019 start_in SHALL be ignored in SHIFT and DONE (no queuing); minimum spacing between accepted starts is WIDTH+2 cycles.
REQ-020 S_out and C_out SHALL hold the last result until the next DONE and SHALL NOT show intermediate values.
REQ-021 Arithmetic SHALL be modulo 2^WIDTH, with C_out as bit WIDTH of A+B+C_in.
REQ-022 Changes to A_in, B_in or C_in after the accepting edge SHALL NOT affect the result in progress.

Reset
REQ-023 When rst_in is asserted, the FSM SHALL go to IDLE and the counter, shift registers, carry flop, S_out, C_out, busy_out and done_out SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-024 Reset during SHIFT or DONE SHALL abort the addition: no done_out pulse, and S_out/C_out read 0.
REQ-025 While rst_in is high, start_in SHALL be ignored; the first start_in accepted is at the first rising edge after release.

Configuration
REQ-026 Macro BIT_SERIAL_ADDER_OVF_EN: when defined, the block SHALL add output V_out (1 bit, reset 0), loaded in DONE with (carry into MSB) XOR (carry out of MSB), i.e. signed overflow.
REQ-027 When BIT_SERIAL_ADDER_OVF_EN is undefined, port V_out and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-028 Start at edge k with A=0x0F, B=0x01, C_in=0 -> done_out=1 only at cycle k+9; S_out=0x10, C_out=0; busy_out high cycles k+1..k+9.
REQ-029 A=0xFF, B=0x01, C_in=1 -> S_out=0x01, C_out=1; with the OVF macro, V_out=0.
REQ-030 With the OVF macro, A=0x7F, B=0x01, C_in=0 -> S_out=0x80, C_out=0, V_out=1.
REQ-031 start_in held high continuously with A changing every cycle -> accepts at k, k+10, k+20; each result matches the operands latched at its accepting edge.
REQ-032 rst_in pulsed at cycle k+4 of an addition -> outputs 0 asynchronously, no done_out; a new start after release yields the correct sum.
